// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types and constants
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem req/ready handshake, IF/ID register
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Br_taken,
  input  logic [31:0]        Br_Addr,
  input  logic               Freeze,
  output logic               Imem_Req,
  output logic [31:0]        Imem_Addr,
  input  logic               Imem_Ready,
  input  logic [INSTR_W-1:0] Imem_Data,
  output logic [31:0]        IF_PC,
  output logic [INSTR_W-1:0] IF_Instr,
  output logic               IF_Valid
);

  fetch_state_t       state, state_nxt;
  logic [31:0]        pc;
  logic [31:0]        pc_inc;
  logic [31:0]        drop_addr;
  logic [INSTR_W-1:0] hold_buf;

  assign pc_inc = pc + PC_INC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (Br_taken)                   state_nxt = Imem_Ready ? S_REQ : S_DROP;
        else if (Imem_Ready && Freeze)  state_nxt = S_HOLD;
      end
      S_HOLD: if (Br_taken || !Freeze) state_nxt = S_REQ;
      S_DROP: if (Imem_Ready)          state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // S_DROP keeps presenting the abandoned address until memory completes it
  always_comb begin
    Imem_Req  = (state == S_REQ) || (state == S_DROP);
    Imem_Addr = (state == S_DROP) ? drop_addr : pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      drop_addr <= 32'h0;
      hold_buf  <= '0;
      IF_PC     <= 32'h0;
      IF_Instr  <= '0;
      IF_Valid  <= 1'b0;
    end else if (Br_taken) begin
      pc       <= Br_Addr;
      IF_Valid <= 1'b0;
      hold_buf <= '0;
      if (state == S_REQ && !Imem_Ready) drop_addr <= pc;
    end else begin
      case (state)
        S_REQ: begin
          if (Imem_Ready) begin
            if (!Freeze) begin
              IF_Instr <= Imem_Data;
              IF_PC    <= pc_inc;
              IF_Valid <= 1'b1;
              pc       <= pc_inc;
            end else begin
              hold_buf <= Imem_Data;
            end
          end else if (!Freeze) begin
            IF_Valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!Freeze) begin
            IF_Instr <= hold_buf;
            IF_PC    <= pc_inc;
            IF_Valid <= 1'b1;
            pc       <= pc_inc;
          end
        end
        S_DROP: begin
          if (!Freeze) IF_Valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
